// File: rtl/noc_output_arbiter.sv
// Output-port allocator for a five-input NoC router: round-robin arbitration,
// wormhole locking until the tail flit, and credit-gated forwarding downstream.
module noc_output_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int DATA_W    = 16,
    parameter int CREDITS   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS-1:0]          tail_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   data_i,
    input  logic                          credit_i,
    output logic [NUM_PORTS-1:0]          pop_o,
    output logic [NUM_PORTS-1:0]          grant_o,
    output logic [DATA_W-1:0]             data_o,
    output logic                          en_o,
    output logic                          credit_err_o
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(CREDITS + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      rr_ptr_nxt;
    logic [PTR_W-1:0]      owner;
    logic [PTR_W-1:0]      owner_nxt;
    logic [NUM_PORTS-1:0]  grant_nxt;
    logic [CNT_W-1:0]      credits;
    logic [PTR_W-1:0]      pick;
    logic                  pick_vld;
    logic                  xfer_p0;
    logic                  owner_tail;
    logic                  credit_ovf;
    logic [DATA_W-1:0]     fwd_p0;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == NUM_PORTS - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Increment saturates at the ceiling; decrement is only requested when the count is non-zero.
    function automatic logic [CNT_W-1:0] credit_next(input logic [CNT_W-1:0] cnt,
                                                     input logic take,
                                                     input logic give);
        if (take && !give) begin
            return cnt - 1'b1;
        end
        if (give && !take && (cnt != CNT_W'(CREDITS))) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

    // Search order starts at rr_ptr; scanning offsets downward lets the smallest offset win.
    always_comb begin
        int sel;
        sel      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            sel = int'(rr_ptr) + i;
            if (sel >= NUM_PORTS) begin
                sel = sel - NUM_PORTS;
            end
            if (req_i[sel]) begin
                pick     = PTR_W'(sel);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        fwd_p0 = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant_o[k]) begin
                fwd_p0 = fwd_p0 | data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer_p0    = (state == LOCKED) && ((req_i & grant_o) != '0) && (credits != '0);
    assign owner_tail = (tail_i & grant_o) != '0;
    assign pop_o      = xfer_p0 ? grant_o : '0;
    assign credit_ovf = credit_i && !xfer_p0 && (credits == CNT_W'(CREDITS));

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        grant_nxt  = grant_o;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = LOCKED;
                    owner_nxt = pick;
                    grant_nxt = NUM_PORTS'(1) << pick;
                end
            end
            LOCKED: begin
                if (xfer_p0 && owner_tail) begin
                    state_nxt  = IDLE;
                    grant_nxt  = '0;
                    rr_ptr_nxt = wrap_inc(owner);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Stage p0 -> p1: registered link outputs and arbitration state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            grant_o      <= '0;
            credits      <= CNT_W'(CREDITS);
            data_o       <= '0;
            en_o         <= 1'b0;
            credit_err_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            owner   <= owner_nxt;
            grant_o <= grant_nxt;
            credits <= credit_next(credits, xfer_p0, credit_i);
            en_o    <= xfer_p0;
            if (xfer_p0) begin
                data_o <= fwd_p0;
            end
            if (credit_ovf) begin
                credit_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: queue-fed sources, a cycle reference model of the
// allocation rules, directed scenarios and a randomized run.
module tb_noc_output_arbiter;

    localparam int N = 5;
    localparam int W = 16;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_i;
    logic [N-1:0]   tail_i;
    logic [N*W-1:0] data_i;
    logic           credit_i;
    logic [N-1:0]   pop_o;
    logic [N-1:0]   grant_o;
    logic [W-1:0]   data_o;
    logic           en_o;
    logic           credit_err_o;

    noc_output_arbiter #(.NUM_PORTS(N), .DATA_W(W), .CREDITS(C)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .tail_i(tail_i), .data_i(data_i),
        .credit_i(credit_i), .pop_o(pop_o), .grant_o(grant_o), .data_o(data_o),
        .en_o(en_o), .credit_err_o(credit_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source queues hold {tail, data}; the head is presented first-word-fall-through.
    logic [16:0] srcq [N][$];
    logic [15:0] outlog [$];
    int          grantlog [$];

    int           m_owner;
    int           m_ptr;
    int           m_cr;
    bit           m_err;
    bit           m_en;
    logic [15:0]  m_dout;
    int           outst;
    bit           auto_credit;
    bit           gap_en;
    logic [N-1:0] prev_grant;

    function automatic logic [N-1:0] m_grant();
        return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endfunction

    function automatic bit m_xfer();
        return (m_owner >= 0) && req_i[m_owner] && (m_cr > 0);
    endfunction

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (srcq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic reset_model();
        m_owner = -1; m_ptr = 0; m_cr = C; m_err = 0; m_en = 0; m_dout = '0;
        outst = 0; prev_grant = '0;
        for (int k = 0; k < N; k++) srcq[k].delete();
    endtask

    task automatic push_pkt(input int port, input logic [15:0] base, input int len);
        for (int i = 0; i < len; i++) srcq[port].push_back({(i == len - 1), 16'(base + 16'(i))});
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            bit gap;
            gap = gap_en && ($urandom_range(0, 4) == 0);
            req_i[k] = (srcq[k].size() > 0) && !gap;
            if (srcq[k].size() > 0) begin
                tail_i[k]         = srcq[k][0][16];
                data_i[k*W +: W]  = srcq[k][0][15:0];
            end else begin
                tail_i[k]         = 1'($urandom);
                data_i[k*W +: W]  = 16'($urandom);
            end
        end
        credit_i = 1'b0;
        if (auto_credit && outst > 0 && $urandom_range(0, 2) != 0) begin
            credit_i = 1'b1;
            outst--;
        end
    endtask

    // Mid-cycle comparison of every output against the model.
    task automatic settle();
        #3;
        check("grant", 32'(grant_o), 32'(m_grant()));
        check("pop", 32'(pop_o), m_xfer() ? 32'(m_grant()) : 32'd0);
        check("en", 32'(en_o), 32'(m_en));
        check("data", 32'(data_o), 32'(m_dout));
        check("credit_err", 32'(credit_err_o), 32'(m_err));
        check("credits", 32'(dut.credits), 32'(m_cr));
        check("rr_ptr", 32'(dut.rr_ptr), 32'(m_ptr));
        if (en_o) begin
            outlog.push_back(data_o);
            outst++;
        end
        if (grant_o != '0 && prev_grant == '0) begin
            for (int k = 0; k < N; k++) if (grant_o[k]) grantlog.push_back(k);
        end
        prev_grant = grant_o;
    endtask

    task automatic advance();
        bit x;
        int o;
        x = m_xfer();
        o = m_owner;
        m_en = x;
        if (x) m_dout = data_i[o*W +: W];
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner < 0 && req_i[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
            end
        end else if (x && tail_i[o]) begin
            m_ptr = (o + 1) % N;
            m_owner = -1;
        end
        m_cr = m_cr - int'(x) + int'(credit_i);
        if (m_cr > C) begin
            m_cr = C;
            m_err = 1'b1;
        end
        if (x) void'(srcq[o].pop_front());
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic wait_idle(input int limit, input bit need_full);
        int n;
        n = 0;
        while ((!all_empty() || m_owner >= 0 || (need_full && m_cr != C)) && n < limit) begin
            cyc();
            n++;
        end
        check("idle_timeout", 32'(n < limit), 32'd1);
        repeat (2) cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr [9];
        int npop;
        int n;
        rst = 1'b0; req_i = '0; tail_i = '0; data_i = '0; credit_i = 1'b0;
        auto_credit = 0; gap_en = 0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        settle();
        check("reset_data", 32'(data_o), 32'd0);
        advance();

        // Single request: grant and pop at cycle 1, output at 2, release visible by 3.
        push_pkt(0, 16'hA5A5, 1);
        drive();
        settle(); check("t1_c0_grant", 32'(grant_o), 32'd0); advance();
        settle(); check("t1_c1_grant", 32'(grant_o), 32'd1); check("t1_c1_pop", 32'(pop_o), 32'd1); advance();
        settle(); check("t1_c2_en", 32'(en_o), 32'd1); check("t1_c2_data", 32'(data_o), 32'hA5A5); advance();
        settle(); check("t1_c3_grant", 32'(grant_o), 32'd0); check("t1_c3_ptr", 32'(dut.rr_ptr), 32'd1); advance();
        auto_credit = 1;

        // Round robin over ports 0,2,4 with the pointer starting at 1.
        grantlog.delete();
        for (int i = 0; i < 3; i++) begin
            push_pkt(0, 16'h0100 + 16'(i), 1);
            push_pkt(2, 16'h0200 + 16'(i), 1);
            push_pkt(4, 16'h0400 + 16'(i), 1);
        end
        drive();
        wait_idle(300, 0);
        exp_rr = '{2, 4, 0, 2, 4, 0, 2, 4, 0};
        check("rr_count", 32'(grantlog.size()), 32'd9);
        for (int i = 0; i < 9 && i < grantlog.size(); i++) check("rr_order", 32'(grantlog[i]), 32'(exp_rr[i]));

        // Wormhole lock: port 1's packet is contiguous while port 3 waits.
        wait_idle(100, 1);
        outlog.delete();
        push_pkt(1, 16'h1001, 3);
        push_pkt(3, 16'h3000, 1);
        push_pkt(3, 16'h3100, 1);
        drive();
        wait_idle(200, 1);
        check("wh_count", 32'(outlog.size()), 32'd5);
        if (outlog.size() == 5) begin
            check("wh_f0", 32'(outlog[0]), 32'h1001);
            check("wh_f1", 32'(outlog[1]), 32'h1002);
            check("wh_f2", 32'(outlog[2]), 32'h1003);
            check("wh_f3", 32'(outlog[3]), 32'h3000);
            check("wh_f4", 32'(outlog[4]), 32'h3100);
        end

        // Credit stall: four flits go, then one per returned credit.
        auto_credit = 0;
        outlog.delete();
        push_pkt(2, 16'h2000, 6);
        drive();
        repeat (12) cyc();
        check("stall_count", 32'(outlog.size()), 32'd4);
        settle();
        check("stall_pop", 32'(pop_o), 32'd0);
        check("stall_credits", 32'(dut.credits), 32'd0);
        advance();
        for (int p = 0; p < 2; p++) begin
            credit_i = 1'b1;
            outst--;
            cyc();
            repeat (4) cyc();
            check("stall_release", 32'(outlog.size()), 32'(5 + p));
        end
        auto_credit = 1;
        wait_idle(100, 1);

        // Transfer and credit in the same cycle, then overflow credit.
        auto_credit = 0;
        push_pkt(0, 16'h5A5A, 1);
        drive();
        cyc();
        credit_i = 1'b1;
        settle(); check("simul_pop", 32'(pop_o), 32'd1); advance();
        settle(); check("simul_credits", 32'(dut.credits), 32'd4); advance();
        credit_i = 1'b1;
        cyc();
        settle(); check("err_set", 32'(credit_err_o), 32'd1); advance();
        repeat (5) cyc();
        settle(); check("err_sticky", 32'(credit_err_o), 32'd1); advance();
        outst = 0;
        auto_credit = 1;

        // Asynchronous reset during the second flit of a packet.
        push_pkt(2, 16'h6200, 1);
        drive();
        wait_idle(100, 0);
        push_pkt(3, 16'h6300, 3);
        drive();
        npop = 0;
        n = 0;
        while (npop < 2 && n < 50) begin
            settle();
            if (pop_o[3]) npop++;
            if (npop < 2) advance();
            n++;
        end
        check("rst_reach_flit2", 32'(npop), 32'd2);
        #1;
        rst = 1'b0;
        #1;
        check("rst_en", 32'(en_o), 32'd0);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_pop", 32'(pop_o), 32'd0);
        check("rst_credits", 32'(dut.credits), 32'd4);
        check("rst_ptr", 32'(dut.rr_ptr), 32'd0);
        check("rst_err", 32'(credit_err_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        reset_model();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_pkt(1, 16'h7100, 1);
        push_pkt(4, 16'h7400, 1);
        drive();
        cyc();
        settle(); check("rst_rearb", 32'(grant_o), 32'b00010); advance();
        wait_idle(100, 1);

        // Randomized traffic with request gaps and delayed credit returns.
        gap_en = 1;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                int p;
                p = $urandom_range(0, N - 1);
                if (srcq[p].size() < 8) push_pkt(p, 16'($urandom), $urandom_range(1, 4));
            end
            cyc();
        end
        gap_en = 0;
        wait_idle(500, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Allocates one router output port among the five input queues of a NoC router: local plus N/S/E/W.
- Uses round-robin arbitration with wormhole packet locking. Once a port is granted, it keeps the output until its tail flit has passed.
- Drives the pop request to the granted queue, registers the forwarded 16-bit flit onto the output link, and gates transfers with a credit counter that tracks free slots in the downstream input queue.

Parameters:
- NUM_PORTS, 5, number of requesting input queues.
- DATA_W, 16, flit width.
- CREDITS, 4, downstream queue depth; reset value and ceiling of the credit count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_i  input  NUM_PORTS  bit k: queue k holds a flit addressed to this output (its req_port_addr line for this port).
- tail_i  input  NUM_PORTS  bit k: the flit currently at the head of queue k is a tail flit.
- data_i  input  NUM_PORTS*DATA_W  head flits, first-word-fall-through; queue k occupies bits [k*DATA_W +: DATA_W].
- credit_i  input  1  one-cycle pulse: downstream freed one slot.
- pop_o  output  NUM_PORTS  pop_req to queue k; combinational, at most one bit high.
- grant_o  output  NUM_PORTS  one-hot current owner; all zero when idle.
- data_o  output  DATA_W  registered flit to the downstream queue.
- en_o  output  1  registered write enable qualifying data_o.
- credit_err_o  output  1  sticky: credit_i arrived while the count was already CREDITS.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant_o=0, credits=CREDITS, data_o=0, en_o=0, credit_err_o=0.
  - Reset asserted mid-packet abandons the packet. No partial flush; upstream and downstream are reset together.
- State machine, IDLE to LOCKED:
  - If IDLE and req_i!=0, pick the first k with req_i[k]=1, searching k = rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
  - Next state is LOCKED, with grant_o one-hot at k and owner=k.
  - Arbitration takes one cycle. No pop happens in IDLE.
- State machine, transfers in LOCKED:
  - A transfer happens when req_i[owner]=1 and credits>0. In that case pop_o[owner]=1 combinationally in the same cycle.
  - On the following edge: data_o <= data_i[owner], en_o <= 1, credits decrements.
  - In any other cycle, en_o <= 0 and data_o holds its value.
  - Latency: request at cycle 0, grant at cycle 1, pop at cycle 1, en_o at cycle 2. Streaming after that is one flit per cycle while credits are available.
- State machine, LOCKED back to IDLE:
  - If a transfer occurs with tail_i[owner]=1, next state is IDLE, grant_o=0, rr_ptr=(owner+1) mod NUM_PORTS.
  - A single-flit packet (head is also tail) releases after one transfer.
  - The earliest the next grant can appear is two cycles after the previous tail's pop.
- Lock holding:
  - If the owner's req_i drops mid-packet (queue temporarily empty) or credits=0, the lock is held and no pop occurs.
  - Requests from other ports are ignored until release.
- Credits:
  - Next count = credits − transfer + credit_i.
  - A transfer and credit_i in the same cycle leave the count unchanged.
  - credit_i while credits=CREDITS and no transfer: the count saturates and credit_err_o sets, cleared only by reset.
  - Credits never underflow, because transfers are blocked at 0.
- Width: the credit counter is $clog2(CREDITS+1) bits. The rr_ptr wraps from NUM_PORTS−1 to 0.
- Invariants: pop_o and grant_o are one-hot or zero, and pop_o is a subset of grant_o. X on inputs must not corrupt state while in IDLE with req_i=0.

Test Plan:
- Reset, single request:
  - Stimulus: deassert reset; req_i=00001, data_i[0]=16'hA5A5, tail_i[0]=1.
  - Required: grant_o=00001 at cycle 1, pop_o[0]=1 at cycle 1; data_o=16'hA5A5 and en_o=1 at cycle 2; grant_o=0 and rr_ptr=1 at cycle 3.
- Round-robin fairness:
  - Stimulus: ports 0, 2, 4 continuously request single-flit packets.
  - Required: grant order 0, 2, 4, 0, 2, …; no port is granted twice before the others.
- Wormhole lock:
  - Stimulus: port 1 sends a 3-flit packet (16'h1001, 16'h1002, 16'h1003 with tail); port 3 requests throughout.
  - Required: all three flits are output contiguously before port 3 is granted; no interleaving.
- Credit stall:
  - Stimulus: CREDITS=4; port 2 sends 6 flits with no credit_i.
  - Required: en_o pulses exactly 4 times and then stalls with pop_o=0. Each single credit_i pulse releases exactly one more flit.
- Simultaneous events:
  - Stimulus: a transfer and credit_i in the same cycle.
  - Required: the count is unchanged. Then credit_i at full count sets credit_err_o=1, which stays set.
- Reset mid-packet:
  - Stimulus: assert rst asynchronously during the 2nd flit of a packet.
  - Required: outputs immediately take reset values (en_o=0, grant_o=0, credits=4, rr_ptr=0). After release, a new request is arbitrated from port 0.
